// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arb_pkg
//  Description : Shared widths and FSM state encoding for the data-memory
//                arbiter (core requester vs. host/loader requester).
//  Revision    : 1.0  initial release
// ============================================================================
package dm_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Requester indices as seen on the winner / last-grant signals.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage : dm_arb_pkg
`default_nettype wire

// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter_if
//  Description : Bundle of the two requester handshakes, the data-memory port
//                and the busy flag. The arbiter uses the slave view; the
//                requesters/memory side uses the master view.
//  Revision    : 1.0  initial release
// ============================================================================
interface dm_arbiter_if;
    import dm_arb_pkg::*;

    // Core requester
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    // Host / loader requester
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    // Data-memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_we, mem_wdata,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_we, mem_wdata,
        input  busy
    );

endinterface : dm_arbiter_if
`default_nettype wire

// File: rtl/dm_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arb_pick
//  Description : Winner selection between the core (0) and host (1)
//                requesters. Purely combinational.
//                DM_ARB_ROUND_ROBIN_EN defined   : contested grant goes to
//                                                   the requester not granted
//                                                   last.
//                DM_ARB_ROUND_ROBIN_EN undefined : contested grant always
//                                                   goes to the core.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  wire logic i_req0,
    input  wire logic i_req1,
    input  wire logic i_last,
    output logic      o_winner
);

`ifdef DM_ARB_ROUND_ROBIN_EN
    // Alternate on contention; a lone requester always wins.
    always_comb begin
        o_winner = i_last;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last;
        end else if (i_req0) begin
            o_winner = REQ_CORE;
        end else if (i_req1) begin
            o_winner = REQ_HOST;
        end
    end
`else
    // Fixed priority to the core. i_last only fills the no-request case,
    // where the winner is never consumed.
    always_comb begin
        o_winner = i_last;
        if (i_req0) begin
            o_winner = REQ_CORE;
        end else if (i_req1) begin
            o_winner = REQ_HOST;
        end
    end
`endif

endmodule : dm_arb_pick
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-requester data-memory arbiter. Three-state FSM
//                IDLE -> ACCESS -> RESP -> IDLE; one transaction every three
//                cycles. The winner's request is latched on the grant edge,
//                driven to memory during ACCESS, and the read data and Ack
//                are registered at the end of RESP.
//                Build option DM_ARB_ROUND_ROBIN_EN adds a last-grant pointer
//                for round-robin contention handling.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_arbiter
    import dm_arb_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    dm_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_next;

    logic              w_grant;
    logic              w_winner;
    logic              w_last;

    logic              r_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    // Requests are only looked at while idle.
    assign w_grant = (r_state == ST_IDLE) && (bus.req0 || bus.req1);

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic r_last;

    // Remember who was granted most recently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_grant) begin
            r_last <= w_winner;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = 1'b0;
`endif

    dm_arb_pick u_pick (
        .i_req0   (bus.req0),
        .i_req1   (bus.req1),
        .i_last   (w_last),
        .o_winner (w_winner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: wait for a request, then walk ACCESS and RESP unconditionally.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.req0 || bus.req1) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Latch the winning request on the grant edge; hold it until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_win   <= w_winner;
            r_we    <= w_winner ? bus.we1    : bus.we0;
            r_addr  <= w_winner ? bus.addr1  : bus.addr0;
            r_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
        end
    end

    // Close out RESP: pulse the winner's Ack and capture read data for reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= (r_state == ST_RESP) && (r_win == REQ_CORE);
            r_ack1 <= (r_state == ST_RESP) && (r_win == REQ_HOST);
            if ((r_state == ST_RESP) && !r_we) begin
                if (r_win == REQ_HOST) begin
                    r_rdata1 <= bus.mem_rdata;
                end else begin
                    r_rdata0 <= bus.mem_rdata;
                end
            end
        end
    end

    // The write strobe is gated by reset so an interrupted write never lands.
    assign bus.mem_we    = (r_state == ST_ACCESS) && r_we && !rst;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = (r_state != ST_IDLE);

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;

endmodule : dm_arbiter
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Directed self-checking bench for dm_arbiter with a small
//                synchronous-read memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] mem [0:255];
    logic       mem_loaded = 1'b0;

    dm_arbiter_if bus ();

    dm_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, write on the strobe.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[8'h02] <= 8'h5A;
            mem[8'h04] <= 8'hFB;
            mem_loaded <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++;
        if ({bus.ack0, bus.ack1} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {bus.ack0, bus.ack1}); end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_bus: got %h want 0000", {bus.mem_addr, bus.mem_wdata}); end
        n_checks++;
        if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", {bus.rdata0, bus.rdata1}); end
    endtask

    task automatic test_read();
        int ack_cyc = 0;
        int we_cyc  = 0;
        int bad_ack = 0;
        logic [7:0] rd_at_ack = 8'h00;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h04;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (bus.mem_we) we_cyc++;
            if (bus.ack1) bad_ack++;
            if (bus.ack0) begin
                ack_cyc   = cyc;
                rd_at_ack = bus.rdata0;
                bus.req0  = 1'b0;
                break;
            end
        end
        repeat (2) begin
            @(negedge clk);
            if (bus.mem_we) we_cyc++;
            if (bus.ack0 || bus.ack1) bad_ack++;
        end
        n_checks++;
        if (ack_cyc !== 3) begin n_fail++; $display("FAIL read_latency: ack cycle %0d want 3", ack_cyc); end
        n_checks++;
        if (rd_at_ack !== 8'hFB) begin n_fail++; $display("FAIL read_rdata0: got %h want fb", rd_at_ack); end
        n_checks++;
        if (we_cyc !== 0) begin n_fail++; $display("FAIL read_no_write: mem_we cycles %0d want 0", we_cyc); end
        n_checks++;
        if (bad_ack !== 0) begin n_fail++; $display("FAIL read_stray_ack: got %0d want 0", bad_ack); end
        n_checks++;
        if (bus.rdata0 !== 8'hFB) begin n_fail++; $display("FAIL read_rdata0_hold: got %h want fb", bus.rdata0); end
    endtask

    task automatic test_write();
        int ack_cyc  = 0;
        int we_cyc   = 0;
        int busy_cyc = 0;
        int bad_ack  = 0;
        logic [15:0] we_bus = 16'h0000;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h01; bus.wdata1 = 8'h03;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.ack0) bad_ack++;
            if (bus.mem_we) begin
                we_cyc++;
                we_bus = {bus.mem_addr, bus.mem_wdata};
            end
            if (bus.ack1) begin
                ack_cyc  = cyc;
                bus.req1 = 1'b0;
                break;
            end
        end
        @(negedge clk);
        n_checks++;
        if (ack_cyc !== 3) begin n_fail++; $display("FAIL write_latency: ack cycle %0d want 3", ack_cyc); end
        n_checks++;
        if (busy_cyc !== 2) begin n_fail++; $display("FAIL write_busy: busy cycles %0d want 2", busy_cyc); end
        n_checks++;
        if (we_cyc !== 1) begin n_fail++; $display("FAIL write_we_count: got %0d want 1", we_cyc); end
        n_checks++;
        if (we_bus !== 16'h0103) begin n_fail++; $display("FAIL write_mem_bus: got %h want 0103", we_bus); end
        n_checks++;
        if (mem[8'h01] !== 8'h03) begin n_fail++; $display("FAIL write_mem: got %h want 03", mem[8'h01]); end
        n_checks++;
        if ({bus.rdata1, bus.rdata0} !== 16'h00FB) begin n_fail++; $display("FAIL write_rdata_kept: got %h want 00fb", {bus.rdata1, bus.rdata0}); end
        n_checks++;
        if ({bus.busy, bus.ack1, logic'(bad_ack != 0)} !== 3'b000) begin n_fail++; $display("FAIL write_single: busy/ack1/stray got %b want 000", {bus.busy, bus.ack1, logic'(bad_ack != 0)}); end
    endtask

    task automatic test_contention();
        int   n_acks = 0;
        int   both   = 0;
        logic [2:0] order = 3'b000;
        logic [2:0] exp_order;
        int   first_cyc = 0;
        int   last_cyc  = 0;
`ifdef DM_ARB_ROUND_ROBIN_EN
        exp_order = 3'b010;
`else
        exp_order = 3'b000;
`endif
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h04;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h04;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (bus.ack0 && bus.ack1) both++;
            if (bus.ack0 || bus.ack1) begin
                order[2 - n_acks] = bus.ack1;
                if (n_acks == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_acks++;
                if (n_acks == 3) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (n_acks !== 3) begin n_fail++; $display("FAIL contend_count: got %0d acks want 3", n_acks); end
        n_checks++;
        if (order !== exp_order) begin n_fail++; $display("FAIL contend_order: got %b want %b", order, exp_order); end
        n_checks++;
        if (last_cyc - first_cyc !== 6) begin n_fail++; $display("FAIL contend_spacing: got %0d want 6", last_cyc - first_cyc); end
        n_checks++;
        if (both !== 0) begin n_fail++; $display("FAIL contend_dual_ack: got %0d want 0", both); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL contend_idle: busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int bad_ack = 0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h02; bus.wdata0 = 8'hFF;
        @(negedge clk);
        n_checks++;
        if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_access: mem_we %b want 1", bus.mem_we); end
        bus.req0 = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_gate: mem_we %b want 0", bus.mem_we); end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.mem_addr} !== 9'h000) begin n_fail++; $display("FAIL rstmid_idle: busy/addr %h want 000", {bus.busy, bus.mem_addr}); end
        repeat (4) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) bad_ack++;
        end
        n_checks++;
        if (bad_ack !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d want 0", bad_ack); end
        n_checks++;
        if (mem[8'h02] !== 8'h5A) begin n_fail++; $display("FAIL rstmid_mem: got %h want 5a", mem[8'h02]); end
    endtask

    task automatic test_back_to_back();
        int n_acks = 0;
        int c0 = 0;
        int c1 = 0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h04;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (bus.ack0) begin
                if (n_acks == 0) c0 = cyc; else c1 = cyc;
                n_acks++;
                if (n_acks == 2) begin
                    bus.req0 = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (n_acks !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d acks want 2", n_acks); end
        n_checks++;
        if (c0 !== 3) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 3", c0); end
        n_checks++;
        if (c1 - c0 !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 3", c1 - c0); end
        n_checks++;
        if ({bus.busy, bus.rdata0} !== 9'h0FB) begin n_fail++; $display("FAIL b2b_end: busy/rdata0 %h want 0fb", {bus.busy, bus.rdata0}); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dm_arbiter
`default_nettype wire

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 Req0  input  1  core requester access request; held high until Ack0.
REQ-004 We0  input  1  core: 1 = write, 0 = read; valid while Req0 high.
REQ-005 Addr0  input  8  core data-memory address.
REQ-006 Wdata0  input  8  core write data.
REQ-007 Ack0  output  1  core transaction complete, one-cycle pulse.
REQ-008 Rdata0  output  8  core read data, valid when Ack0 high.
REQ-009 Req1, We1, Addr1[8], Wdata1[8], Ack1, Rdata1: host/loader requester, same meanings as REQ-003..REQ-008.
REQ-010 MemAddr  output  8  data-memory address.
REQ-011 MemWe  output  1  data-memory write enable.
REQ-012 MemWdata  output  8  data-memory write data.
REQ-013 MemRdata  input  8  data-memory read data, valid one cycle after MemAddr.
REQ-014 Busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states, IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when any Req is high, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 Req/We/Addr/Wdata SHALL be sampled only in IDLE; the winner's We/Addr/Wdata SHALL be registered on the IDLE->ACCESS edge and held until IDLE.
REQ-017 MemAddr and MemWdata SHALL drive the registered winner fields; MemWe SHALL be high only in ACCESS for a write and forced low while Reset is high.
REQ-018 In RESP, MemRdata SHALL be captured into the winner's Rdata register and the winner's Ack SHALL be high for exactly that one cycle; the loser's Ack SHALL stay low.
REQ-019 Latency: with Req sampled at edge N, Ack SHALL be high in the cycle after edge N+2; peak throughput SHALL be one transaction per 3 cycles.
REQ-020 Rdata0/Rdata1 SHALL hold their last captured value until the next read completes for that requester; writes SHALL leave Rdata unchanged.
REQ-021 A Req still high at the edge ending the Ack cycle SHALL be treated as a new back-to-back request.
REQ-022 When only one Req is high in IDLE, that requester SHALL win.
REQ-023 When both Reqs are high in IDLE, the winner SHALL be chosen per REQ-027/REQ-028.
REQ-024 A Req that drops before its Ack SHALL NOT abort an accepted transaction; an unaccepted dropped Req SHALL be ignored.

Reset
REQ-025 On a Reset edge, the state SHALL go to IDLE; Ack0, Ack1, MemWe, Busy, MemAddr, MemWdata, Rdata0, Rdata1 and the last-grant pointer SHALL clear to 0.
REQ-026 A Reset mid-ACCESS or mid-RESP SHALL drop the transaction: no Ack, and no write while Reset is high.

Configuration
REQ-027 With DM_ARB_ROUND_ROBIN_EN defined, a contested grant SHALL go to the requester not granted last; the last-grant pointer SHALL update on every grant.
REQ-028 Without DM_ARB_ROUND_ROBIN_EN, a contested grant SHALL always go to requester 0, and no pointer register SHALL exist.

Structure
REQ-029 Package dm_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and the address/data width parameters (8/8).
REQ-030 The winner selection SHALL be a sub-module dm_arb_pick with inputs Req0, Req1 and the last-grant pointer, and output the winner index; it SHALL contain all macro-dependent logic.

Verification
REQ-031 Single write: Req1=1, We1=1, Addr1=8'h01, Wdata1=8'h03 -> MemWe high one cycle with MemAddr=8'h01 and MemWdata=8'h03; Ack1 pulses on the 3rd cycle; Busy high for 2 cycles.
REQ-032 Single read: memory[8'h04]=8'hFB, Req0 read Addr0=8'h04 -> Ack0 pulses with Rdata0=8'hFB, and MemWe never goes high.
REQ-033 Contention: Req0 and Req1 held high, three grants.
  - With DM_ARB_ROUND_ROBIN_EN, the Ack order SHALL be 0,1,0.
  - Without it, the Ack order SHALL be 0,0,0.
REQ-034 Reset mid-operation: Reset high during an ACCESS write of 8'hFF to 8'h02 -> memory[8'h02] unchanged, no Ack, and state IDLE after the edge.
REQ-035 Back-to-back: Req0 held high across its Ack -> second transaction accepted with Acks exactly 3 cycles apart.
